pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32I pipeline. It drives the stall and flush inputs of the IF/ID, DEC/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage forwarding muxes. It also contains a small FSM that freezes the pipeline while a MEM-stage APB/UART transaction waits for pready, with a watchdog timeout and a stall-cycle performance counter.

Parameters:
TIMEOUT_CYCLES, 255, cycles in ACCESS state before the transaction is abandoned and bus_timeout pulses.
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-high reset
Rs1D, Rs2D  in  5  source registers in DEC
Rs1E, Rs2E, RdE  in  5  source and destination registers in EX
RdM, RdW  in  5  destination registers in MEM and WB
RegWriteM, RegWriteW  in  1  register-write enables in MEM and WB
ResultSrcE  in  2  EX result select; 2'b01 = load
PCSrcE  in  1  taken branch or jump resolved in EX
transEnM  in  1  MEM-stage instruction is a peripheral (APB) access
pready  in  1  APB completer ready
ForwardAE, ForwardBE  out  2  00 = regfile, 01 = WB result, 10 = MEM ALU result
StallF, StallD, StallE, StallM  out  1  hold PC, IF/ID, DEC/EX, EX/MEM
FlushD, FlushE, FlushW  out  1  bubble into IF/ID, DEC/EX, MEM/WB
bus_busy  out  1  FSM is in ACCESS
bus_timeout  out  1  one-cycle pulse on watchdog expiry
stall_cnt  out  32  count of cycles with StallF = 1

Behaviour:
- FSM states: IDLE, ACCESS. Registered state, timeout counter, bus_timeout and stall_cnt. All other outputs are combinational.
- Reset: state = IDLE, counter = 0, bus_timeout = 0, stall_cnt = 0. With quiet inputs every output is 0.
- Bus stall: bus_stall = (IDLE & transEnM) | (ACCESS & !pready & !expire).
  - expire = (counter == TIMEOUT_CYCLES - 1) & !pready.
- IDLE -> ACCESS when transEnM. Counter cleared on entry.
- ACCESS:
  - Counter increments each cycle while !pready.
  - pready = 1 -> IDLE. Stall drops in that cycle, so the access instruction advances on the same edge. Counter cleared.
  - expire -> IDLE. bus_timeout = 1 on the next cycle only. Stall released.
- Back-to-back accesses: a new transEnM in the cycle after returning to IDLE starts a new access. No idle gap is required.
- pready already high in the IDLE cycle is ignored. ACCESS is always entered, giving a 2-cycle minimum freeze for an access.
- Load-use stall: lwStall = (ResultSrcE == 2'b01) & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D).
- Stall and flush outputs:
  - StallF = StallD = lwStall | bus_stall.
  - StallE = StallM = bus_stall.
  - FlushW = bus_stall. The WB bubble prevents repeated writeback of a frozen instruction.
  - FlushE = !bus_stall & (lwStall | PCSrcE).
  - FlushD = !bus_stall & PCSrcE.
- Priority: bus_stall overrides all flushes, so a frozen pipeline never loses a branch or load-use bubble. PCSrcE together with lwStall gives FlushD = FlushE = 1 and StallF = StallD = 1; the flush wins in the registers.
- Forwarding for A (B identical with Rs2E):
  - 10 if RegWriteM & RdM != 0 & RdM == Rs1E.
  - Otherwise 01 if RegWriteW & RdW != 0 & RdW == Rs1E.
  - Otherwise 00.
  - MEM has priority over WB. x0 is never forwarded.
- stall_cnt increments by 1 on each clock edge where StallF = 1. It wraps from 0xFFFFFFFF to 0.
- Reset asserted mid-ACCESS returns the FSM to IDLE immediately. All stalls drop asynchronously and the counters clear.

Test Plan:
- Forwarding: RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, Rs1E = 5 -> ForwardAE = 10. Then RegWriteM = 0 -> 01. Then Rs1E = 0 with RdM = RdW = 0 -> 00.
- Load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1, StallE = 0. With RdE = 0 -> all 0.
- Branch: PCSrcE = 1, no other hazards -> FlushD = FlushE = 1, no stalls. stall_cnt unchanged.
- APB access, pready rises after 3 ACCESS cycles:
  - StallF/D/E/M = 1 for 4 cycles (1 IDLE + 3 ACCESS). Drop in the pready cycle.
  - bus_busy high for 4 cycles in total.
  - stall_cnt = 4.
- Timeout with TIMEOUT_CYCLES = 4, pready held 0 -> stall high 4 cycles, released in the 5th cycle, bus_timeout = 1 for exactly one cycle after that, FSM back in IDLE.
- Bus stall + PCSrcE = 1 + lwStall -> FlushD = FlushE = 0 while frozen. After pready, FlushD = FlushE = 1 in the release cycle. Separately, asserting rst mid-ACCESS -> all outputs 0 and stall_cnt = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control signal bundle between the RV32I pipeline datapath and the
// hazard controller. The master side drives pipeline state, the slave side returns controls.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [4:0]  RdM;
  logic [4:0]  RdW;
  logic        RegWriteM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE;
  logic        transEnM;
  logic        pready;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        StallM;
  logic        FlushD;
  logic        FlushE;
  logic        FlushW;
  logic        bus_busy;
  logic        bus_timeout;
  logic [31:0] stall_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
    output ResultSrcE, PCSrcE, transEnM, pready,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, bus_busy, bus_timeout, stall_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
    input  ResultSrcE, PCSrcE, transEnM, pready,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, bus_busy, bus_timeout, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and peripheral-access freeze control for the 5-stage RV32I pipeline,
// with an access watchdog and a count of fetch-stall cycles.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic StIdle   = 1'b0;
  localparam logic StAccess = 1'b1;

  logic            state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
  logic [31:0]     stall_cnt_q;
  logic            expire;
  logic            bus_stall;
  logic            lw_stall;

  // x0 is hardwired to zero, so it is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                         input logic [4:0] rdw, input logic rwm,
                                         input logic rww);
    if (rwm && (rdm != 5'd0) && (rdm == rs)) begin
      return 2'b10;
    end else if (rww && (rdw != 5'd0) && (rdw == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    expire    = (state_q == StAccess) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) && !hz.pready;
    bus_stall = ((state_q == StIdle) && hz.transEnM) ||
                ((state_q == StAccess) && !hz.pready && !expire);
    lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  end

  // A pready already high in IDLE is ignored: every access spends at least one cycle in ACCESS.
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (hz.transEnM) begin
          state_d  = StAccess;
          to_cnt_d = '0;
        end
      end
      StAccess: begin
        if (hz.pready) begin
          state_d  = StIdle;
          to_cnt_d = '0;
        end else if (expire) begin
          state_d   = StIdle;
          to_cnt_d  = '0;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
      if (hz.StallF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  // A bus freeze masks all flushes so branch and load-use bubbles are applied after release.
  always_comb begin
    hz.StallF      = lw_stall | bus_stall;
    hz.StallD      = lw_stall | bus_stall;
    hz.StallE      = bus_stall;
    hz.StallM      = bus_stall;
    hz.FlushW      = bus_stall;
    hz.FlushE      = !bus_stall && (lw_stall || hz.PCSrcE);
    hz.FlushD      = !bus_stall && hz.PCSrcE;
    hz.ForwardAE   = fwd_sel(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
    hz.ForwardBE   = fwd_sel(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
    hz.bus_busy    = (state_q == StAccess);
    hz.bus_timeout = timeout_q;
    hz.stall_cnt   = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: combinational vector table plus
// hand-written bus-access, timeout, priority and reset sequences.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(
    .TIMEOUT_CYCLES(4),
    .TO_W          (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  // ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww;
    logic [1:0] rsrc;
    logic       pcsrc;
    logic [1:0] fa, fb;
    logic [6:0] ctl;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};
  endfunction

  task automatic quiet();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
    hz.RdM = '0; hz.RdW = '0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.ResultSrcE = 2'b00; hz.PCSrcE = 1'b0; hz.transEnM = 1'b0; hz.pready = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    hz.Rs1D = v.rs1d; hz.Rs2D = v.rs2d; hz.Rs1E = v.rs1e; hz.Rs2E = v.rs2e;
    hz.RdE = v.rde; hz.RdM = v.rdm; hz.RdW = v.rdw;
    hz.RegWriteM = v.rwm; hz.RegWriteW = v.rww;
    hz.ResultSrcE = v.rsrc; hz.PCSrcE = v.pcsrc;
    hz.transEnM = 1'b0; hz.pready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{default: 0};
    vecs[1]  = '{default: 0, rdm: 5, rwm: 1, rdw: 5, rww: 1, rs1e: 5, fa: 2'b10};
    vecs[2]  = '{default: 0, rdm: 5, rwm: 0, rdw: 5, rww: 1, rs1e: 5, fa: 2'b01};
    vecs[3]  = '{default: 0, rwm: 1, rww: 1};
    vecs[4]  = '{default: 0, rdm: 3, rwm: 1, rs1e: 3, rdw: 9, rww: 1, rs2e: 9,
                 fa: 2'b10, fb: 2'b01};
    vecs[5]  = '{default: 0, rdm: 6, rwm: 1, rdw: 6, rww: 1, rs2e: 6, fb: 2'b10};
    vecs[6]  = '{default: 0, rsrc: 2'b01, rde: 7, rs2d: 7, ctl: 7'b1100010};
    vecs[7]  = '{default: 0, rsrc: 2'b01};
    vecs[8]  = '{default: 0, rsrc: 2'b00, rde: 7, rs1d: 7};
    vecs[9]  = '{default: 0, rsrc: 2'b01, rde: 7, rs1d: 7, ctl: 7'b1100010};
    vecs[10] = '{default: 0, pcsrc: 1, ctl: 7'b0000110};
    vecs[11] = '{default: 0, pcsrc: 1, rsrc: 2'b01, rde: 7, rs1d: 7, ctl: 7'b1100110};
    vecs[12] = '{default: 0, rsrc: 2'b10, rde: 7, rs1d: 7};

    quiet();
    @(negedge clk);
    #1;
    chk("reset ctl", 32'(ctl_now()), 32'd0);
    chk("reset fwd", {28'd0, hz.ForwardAE, hz.ForwardBE}, 32'd0);
    chk("reset busy", 32'(hz.bus_busy), 32'd0);
    chk("reset timeout", 32'(hz.bus_timeout), 32'd0);
    chk("reset stall_cnt", hz.stall_cnt, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d fa", i), 32'(hz.ForwardAE), 32'(vecs[i].fa));
      chk($sformatf("vec%0d fb", i), 32'(hz.ForwardBE), 32'(vecs[i].fb));
      chk($sformatf("vec%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d busy", i), 32'(hz.bus_busy), 32'd0);
      exp_cnt += int'(vecs[i].ctl[6]);
    end
    @(negedge clk);
    quiet();
    #1;
    chk("table stall_cnt", hz.stall_cnt, 32'(exp_cnt));

    // APB access, pready in the 4th ACCESS cycle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      hz.transEnM = 1'b1;
      hz.pready = (i == 4);
      #1;
      chk($sformatf("apb c%0d ctl", i), 32'(ctl_now()), (i < 4) ? 32'h79 : 32'h0);
      chk($sformatf("apb c%0d busy", i), 32'(hz.bus_busy), (i > 0) ? 32'd1 : 32'd0);
    end
    exp_cnt += 4;
    @(negedge clk);
    quiet();
    #1;
    chk("apb done busy", 32'(hz.bus_busy), 32'd0);
    chk("apb stall_cnt", hz.stall_cnt, 32'(exp_cnt));

    // Watchdog with TIMEOUT_CYCLES = 4
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      hz.transEnM = 1'b1;
      hz.pready = 1'b0;
      #1;
      chk($sformatf("to c%0d stall", i), 32'(hz.StallF), (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("to c%0d busy", i), 32'(hz.bus_busy), (i > 0) ? 32'd1 : 32'd0);
      chk($sformatf("to c%0d pulse", i), 32'(hz.bus_timeout), 32'd0);
    end
    exp_cnt += 4;
    @(negedge clk);
    quiet();
    #1;
    chk("to pulse", 32'(hz.bus_timeout), 32'd1);
    chk("to idle busy", 32'(hz.bus_busy), 32'd0);
    chk("to idle ctl", 32'(ctl_now()), 32'd0);
    @(negedge clk);
    #1;
    chk("to pulse end", 32'(hz.bus_timeout), 32'd0);
    chk("to stall_cnt", hz.stall_cnt, 32'(exp_cnt));

    // Back-to-back accesses with pready held high: early pready is ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hz.transEnM = 1'b1;
      hz.pready = 1'b1;
      #1;
      chk($sformatf("b2b c%0d stall", i), 32'(hz.StallE), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b2b c%0d busy", i), 32'(hz.bus_busy), (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    exp_cnt += 2;
    @(negedge clk);
    quiet();
    #1;
    chk("b2b stall_cnt", hz.stall_cnt, 32'(exp_cnt));

    // Freeze masks branch and load-use flushes until release
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hz.transEnM = 1'b1;
      hz.pready = (i == 2);
      hz.PCSrcE = 1'b1;
      hz.ResultSrcE = 2'b01;
      hz.RdE = 5'd7;
      hz.Rs1D = 5'd7;
      #1;
      chk($sformatf("prio c%0d ctl", i), 32'(ctl_now()), (i < 2) ? 32'h79 : 32'h66);
    end
    exp_cnt += 3;
    @(negedge clk);
    quiet();
    #1;
    chk("prio stall_cnt", hz.stall_cnt, 32'(exp_cnt));

    // Asynchronous reset in the middle of an access
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      hz.transEnM = 1'b1;
    end
    #1;
    chk("rst pre busy", 32'(hz.bus_busy), 32'd1);
    #1;
    rst = 1'b1;
    hz.transEnM = 1'b0;
    #1;
    chk("rst ctl", 32'(ctl_now()), 32'd0);
    chk("rst busy", 32'(hz.bus_busy), 32'd0);
    chk("rst stall_cnt", hz.stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post rst ctl", 32'(ctl_now()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
